// File: rtl/uart_pkg.sv
// Shared types, encodings and helpers for the UART transmitter.
package uart_pkg;

    localparam int unsigned MAX_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_LOW,
        ST_BRK_MARK
    } tx_state_t;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_mode_t;

    typedef enum logic [1:0] {
        STOP_1   = 2'd0,
        STOP_1P5 = 2'd1,
        STOP_2   = 2'd2
    } stop_bits_t;

    localparam logic [2:0] DBITS_8 = 3'd0;
    localparam logic [2:0] DBITS_7 = 3'd1;
    localparam logic [2:0] DBITS_6 = 3'd2;
    localparam logic [2:0] DBITS_5 = 3'd3;
    localparam logic [2:0] DBITS_9 = 3'd4;

    // Number of data bits sent for a data_bits code; unused codes mean 8.
    function automatic logic [3:0] data_len(input logic [2:0] db);
        case (db)
            DBITS_7: return 4'd7;
            DBITS_6: return 4'd6;
            DBITS_5: return 4'd5;
            DBITS_9: return 4'd9;
            default: return 4'd8;
        endcase
    endfunction

    // Raw parity code to mode; unused codes mean no parity.
    function automatic parity_mode_t to_parity(input logic [2:0] pm);
        case (pm)
            3'd1:    return PAR_EVEN;
            3'd2:    return PAR_ODD;
            3'd3:    return PAR_MARK;
            3'd4:    return PAR_SPACE;
            default: return PAR_NONE;
        endcase
    endfunction

    // Raw stop code to stop length; code 3 also means two stop bits.
    function automatic stop_bits_t to_stop(input logic [1:0] sb);
        case (sb)
            2'd0:    return STOP_1;
            2'd1:    return STOP_1P5;
            default: return STOP_2;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo_gen_if.sv
// AXI4-Stream transmit-word interface feeding the UART FIFO.
interface uart_tx_fifo_gen_if #(
    parameter int unsigned DATA_W = 9
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with synchronous active-low flush and occupancy count.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_fifo_gen.sv
// UART transmitter with AXIS input FIFO, configurable framing and break generation.
module uart_tx_fifo_gen
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned BREAK_BITS = 11
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic                            En,
    input  logic                            baud_clk,
    uart_tx_fifo_gen_if.slave               s_axis,
    input  logic [2:0]                      data_bits,
    input  logic [2:0]                      parity_mode,
    input  logic [1:0]                      stop_bits,
    input  logic                            msb_first,
    input  logic                            send_break,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            busy,
    output logic                            tc,
    output logic                            break_done,
    output logic                            txd
);
    localparam int unsigned CW = $clog2(2 * OVERSAMPLE);
    localparam int unsigned BW = (BREAK_BITS > MAX_BITS) ? $clog2(BREAK_BITS + 1) : 4;

    logic srst_n, live_q;
    logic fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [MAX_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]    nbits_q, nbits_d;
    parity_mode_t  pmode_q, pmode_d;
    stop_bits_t    stop_q, stop_d;
    logic par_q, par_d, brk_pend_q, brk_pend_d;
    logic txd_q, txd_d, busy_q, busy_d, tc_q, tc_d, bdone_q, bdone_d;

    logic [MAX_BITS-1:0] word, masked, ordered;
    logic [3:0] n_len, idx;
    logic par_calc, load, bit_end, stop_end, brk_req;

    assign srst_n        = Rst_n & En;
    assign fifo_push     = s_axis.tvalid & s_axis.tready;
    assign s_axis.tready = live_q & ~fifo_full;

    axis_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (Clk),
        .srst_n  (srst_n),
        .push_i  (fifo_push),
        .wdata_i (s_axis.tdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Frame-start values: head word trimmed to N bits, bit order fixed so DATA always shifts LSB out.
    always_comb begin
        word    = MAX_BITS'(fifo_rdata);
        n_len   = data_len(data_bits);
        masked  = word & ((MAX_BITS'(1) << n_len) - MAX_BITS'(1));
        ordered = '0;
        idx     = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < int'(n_len)) begin
                idx        = n_len - 4'd1 - 4'(i);
                ordered[i] = msb_first ? word[idx] : word[i];
            end
        end
        case (to_parity(parity_mode))
            PAR_EVEN: par_calc = ^masked;
            PAR_ODD:  par_calc = ~(^masked);
            PAR_MARK: par_calc = 1'b1;
            default:  par_calc = 1'b0;
        endcase
    end

    // Bit-time and stop-length terminal counts.
    always_comb begin
        bit_end = (cnt_q == CW'(OVERSAMPLE - 1));
        case (stop_q)
            STOP_1:   stop_end = (cnt_q == CW'(OVERSAMPLE - 1));
            STOP_1P5: stop_end = (cnt_q == CW'(OVERSAMPLE + OVERSAMPLE / 2 - 1));
            default:  stop_end = (cnt_q == CW'(2 * OVERSAMPLE - 1));
        endcase
        brk_req = send_break & ~brk_pend_q & (state_q != ST_BRK_LOW) & (state_q != ST_BRK_MARK);
    end

    // Next-state and next-output logic; counters only move on baud_clk pulses.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        nbits_d    = nbits_q;
        pmode_d    = pmode_q;
        stop_d     = stop_q;
        brk_pend_d = brk_pend_q | brk_req;
        tc_d       = 1'b0;
        bdone_d    = 1'b0;
        load       = 1'b0;
        fifo_pop   = 1'b0;
        txd_d      = 1'b1;

        if (baud_clk) begin
            case (state_q)
                ST_IDLE: begin
                    if (brk_pend_q) begin
                        state_d    = ST_BRK_LOW;
                        cnt_d      = '0;
                        bit_d      = '0;
                        brk_pend_d = 1'b0;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end else cnt_d = cnt_q + CW'(1);
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_d   = '0;
                        shreg_d = shreg_q >> 1;
                        if (bit_q == BW'(nbits_q) - BW'(1))
                            state_d = (pmode_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                        else
                            bit_d = bit_q + BW'(1);
                    end else cnt_d = cnt_q + CW'(1);
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_d = ST_STOP;
                        cnt_d   = '0;
                    end else cnt_d = cnt_q + CW'(1);
                end
                ST_STOP: begin
                    if (stop_end) begin
                        cnt_d = '0;
                        if (!brk_pend_q && !fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tc_d    = ~brk_pend_q;
                        end
                    end else cnt_d = cnt_q + CW'(1);
                end
                ST_BRK_LOW: begin
                    if (bit_end) begin
                        cnt_d = '0;
                        if (bit_q == BW'(BREAK_BITS - 1)) begin
                            state_d = ST_BRK_MARK;
                            bit_d   = '0;
                        end else bit_d = bit_q + BW'(1);
                    end else cnt_d = cnt_q + CW'(1);
                end
                ST_BRK_MARK: begin
                    if (bit_end) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        bdone_d = 1'b1;
                    end else cnt_d = cnt_q + CW'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (load) begin
            fifo_pop = 1'b1;
            state_d  = ST_START;
            cnt_d    = '0;
            bit_d    = '0;
            shreg_d  = ordered;
            par_d    = par_calc;
            nbits_d  = n_len;
            pmode_d  = to_parity(parity_mode);
            stop_d   = to_stop(stop_bits);
        end

        case (state_d)
            ST_START, ST_BRK_LOW: txd_d = 1'b0;
            ST_DATA:              txd_d = shreg_d[0];
            ST_PARITY:            txd_d = par_d;
            default:              txd_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; En low behaves exactly like reset.
    always_ff @(posedge Clk) begin
        if (!srst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            nbits_q    <= 4'd8;
            pmode_q    <= PAR_NONE;
            stop_q     <= STOP_1;
            brk_pend_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            tc_q       <= 1'b0;
            bdone_q    <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            nbits_q    <= nbits_d;
            pmode_q    <= pmode_d;
            stop_q     <= stop_d;
            brk_pend_q <= brk_pend_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            tc_q       <= tc_d;
            bdone_q    <= bdone_d;
            live_q     <= 1'b1;
        end
    end

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign tc         = tc_q;
    assign break_done = bdone_q;
endmodule

// File: tb/tb_uart_tx_fifo_gen.sv
// Directed bench for uart_tx_fifo_gen with a per-pulse txd scoreboard.
module tb_uart_tx_fifo_gen;
    localparam int unsigned OS = 8;

    logic       Clk, Rst_n, En, baud_clk, msb_first, send_break;
    logic [2:0] data_bits, parity_mode;
    logic [1:0] stop_bits;
    logic [2:0] fifo_level;
    logic       busy, tc, break_done, txd;

    uart_tx_fifo_gen_if #(.DATA_W(9)) axis ();

    uart_tx_fifo_gen #(.DATA_W(9), .FIFO_DEPTH(4), .OVERSAMPLE(OS), .BREAK_BITS(11)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .baud_clk(baud_clk), .s_axis(axis),
        .data_bits(data_bits), .parity_mode(parity_mode), .stop_bits(stop_bits),
        .msb_first(msb_first), .send_break(send_break), .fifo_level(fifo_level),
        .busy(busy), .tc(tc), .break_done(break_done), .txd(txd)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   nb_model;
    logic acc5;
    logic exp_q[$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_cfg(input logic [2:0] db, input logic [2:0] pm, input logic [1:0] sb, input logic msb);
        data_bits = db; parity_mode = pm; stop_bits = sb; msb_first = msb;
        case (db)
            3'd1: nb_model = 7;
            3'd2: nb_model = 6;
            3'd3: nb_model = 5;
            3'd4: nb_model = 9;
            default: nb_model = 8;
        endcase
    endtask

    task automatic push_rep(input logic v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Expected txd value for every baud pulse of one frame under the current config.
    task automatic expect_frame(input logic [8:0] w);
        logic ones, b;
        ones = 1'b0;
        push_rep(1'b0, OS);
        for (int i = 0; i < nb_model; i++) begin
            b = msb_first ? w[nb_model - 1 - i] : w[i];
            ones ^= b;
            push_rep(b, OS);
        end
        case (parity_mode)
            3'd1: push_rep(ones, OS);
            3'd2: push_rep(~ones, OS);
            3'd3: push_rep(1'b1, OS);
            3'd4: push_rep(1'b0, OS);
            default: ;
        endcase
        push_rep(1'b1, (stop_bits == 2'd0) ? OS : (stop_bits == 2'd1) ? OS + OS / 2 : 2 * OS);
    endtask

    task automatic push_word(input logic [8:0] w);
        axis.tdata = w; axis.tvalid = 1'b1;
        for (int i = 0; i < 20 && axis.tready !== 1'b1; i++) step();
        chk("push_ready", axis.tready, 1);
        step();
        axis.tvalid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (txd === 1'b0) begin ok = 1'b1; break; end
            step();
        end
        chk({tag, "_start"}, ok, 1);
    endtask

    // Pops one expectation per clock (baud held high) starting at the first start-bit cycle.
    task automatic check_stream(input string tag, input logic exp_tc);
        int idx, tcs;
        logic e, drop;
        idx = 0; tcs = 0;
        while (exp_q.size() > 0) begin
            if (idx > 0) begin
                drop = axis.tvalid & axis.tready;
                step();
                send_break = 1'b0;
                if (drop) begin axis.tvalid = 1'b0; acc5 = 1'b1; end
            end
            e = exp_q.pop_front();
            chk($sformatf("%s_txd[%0d]", tag, idx), txd, e);
            if (tc === 1'b1) tcs++;
            idx++;
        end
        chk({tag, "_tc_mid"}, tcs, 0);
        step();
        chk({tag, "_tc_end"}, tc, exp_tc);
        chk({tag, "_busy_end"}, busy, 0);
        step();
        chk({tag, "_tc_pulse"}, tc, 0);
    endtask

    initial begin
        logic [8:0] words [5];
        logic hs;
        int acc, lows, highs, tcs;

        Rst_n = 1'b0; En = 1'b1; baud_clk = 1'b1; send_break = 1'b0; acc5 = 1'b0;
        axis.tdata = '0; axis.tvalid = 1'b0;
        set_cfg(3'd0, 3'd0, 2'd0, 1'b0);
        step(); step();
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tc", tc, 0);
        chk("rst_bdone", break_done, 0);
        chk("rst_tready", axis.tready, 0);
        chk("rst_level", fifo_level, 0);
        Rst_n = 1'b1;
        step();
        chk("run_tready", axis.tready, 1);
        En = 1'b0;
        step();
        chk("en_low_tready", axis.tready, 0);
        En = 1'b1;
        step();

        // 8N1 LSB-first 0xA5
        expect_frame(9'h0A5);
        push_word(9'h0A5);
        wait_start("a5");
        check_stream("a5", 1'b1);

        // 7 bits MSB-first 0x41 under even/odd/mark/space parity
        for (int pm = 1; pm <= 4; pm++) begin
            set_cfg(3'd1, 3'(pm), 2'd0, 1'b1);
            expect_frame(9'h041);
            push_word(9'h041);
            wait_start($sformatf("p%0d", pm));
            check_stream($sformatf("p%0d", pm), 1'b1);
        end

        // 9 bits, space parity, 2 stop bits
        set_cfg(3'd4, 3'd4, 2'd2, 1'b0);
        expect_frame(9'h1FF);
        push_word(9'h1FF);
        wait_start("n9");
        check_stream("n9", 1'b1);

        // 8N1.5 back-to-back, both words queued before pacing starts
        set_cfg(3'd0, 3'd0, 2'd1, 1'b0);
        baud_clk = 1'b0;
        push_word(9'h000);
        push_word(9'h0FF);
        chk("b2b_level", fifo_level, 2);
        expect_frame(9'h000);
        expect_frame(9'h0FF);
        baud_clk = 1'b1;
        wait_start("b2b");
        check_stream("b2b", 1'b1);

        // FIFO fill with pacing gated: four accepted, fifth held
        set_cfg(3'd0, 3'd0, 2'd0, 1'b0);
        baud_clk = 1'b0;
        words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033; words[3] = 9'h044; words[4] = 9'h055;
        axis.tvalid = 1'b1; acc = 0;
        for (int c = 0; c < 8 && acc < 5; c++) begin
            axis.tdata = words[acc];
            hs = axis.tready;
            step();
            if (hs) acc++;
        end
        chk("full_accepted", acc, 4);
        chk("full_tready", axis.tready, 0);
        chk("full_level", fifo_level, 4);
        for (int i = 0; i < 5; i++) expect_frame(words[i]);
        acc5 = 1'b0;
        baud_clk = 1'b1;
        wait_start("full");
        check_stream("full", 1'b1);
        chk("full_fifth_taken", acc5, 1);
        axis.tvalid = 1'b0;

        // Break requested during a frame: frame completes, then break, no tc
        expect_frame(9'h05A);
        push_word(9'h05A);
        wait_start("brkf");
        send_break = 1'b1;
        check_stream("brkf", 1'b0);
        wait_start("brk");
        lows = 0; tcs = 0;
        while (txd === 1'b0 && lows < 200) begin
            lows++;
            step();
            if (tc === 1'b1) tcs++;
        end
        chk("brk_low_len", lows, 88);
        highs = 0;
        while (break_done !== 1'b1 && highs < 50) begin
            if (txd === 1'b1) highs++;
            step();
            if (tc === 1'b1) tcs++;
        end
        chk("brk_mark_len", highs, 8);
        chk("brk_done", break_done, 1);
        chk("brk_busy", busy, 0);
        step();
        chk("brk_done_pulse", break_done, 0);
        chk("brk_no_tc", tcs, 0);

        // Reset in the middle of a break, with a word waiting in the FIFO
        send_break = 1'b1;
        step();
        send_break = 1'b0;
        wait_start("brk2");
        push_word(9'h033);
        chk("brk2_level", fifo_level, 1);
        for (int i = 0; i < 10; i++) step();
        chk("brk2_txd_low", txd, 0);
        Rst_n = 1'b0;
        step();
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tready", axis.tready, 0);
        Rst_n = 1'b1;
        step();
        lows = 0; highs = 0;
        for (int i = 0; i < 150; i++) begin
            if (txd !== 1'b1) lows++;
            if (break_done === 1'b1) highs++;
            step();
        end
        chk("post_rst_idle", lows, 0);
        chk("post_rst_no_bdone", highs, 0);
        chk("post_rst_tready", axis.tready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo_gen.md
Name: uart_tx_fifo_gen

Overview:
Next-generation UART transmitter for the aes_uart IP core. It has a parametrised AXI4-Stream input FIFO and a configurable oversampling ratio. It supports 5–9 data bits, five parity modes, 1/1.5/2 stop bits, MSB/LSB-first ordering and break generation. It sits between the AES output stream and the txd pin and is paced by the shared baud_clk pulse generator.

Parameters:
DATA_W, 9, width of s_axis_tdata; fixed range 5..9, data_bits selects how many are sent
FIFO_DEPTH, 4, input FIFO entries; power of two, >=2
OVERSAMPLE, 8, baud_clk pulses per bit-time; even, >=4
BREAK_BITS, 11, bit-times txd is held low during a break

Ports:
Clk  in  1  system clock
Rst_n  in  1  synchronous reset, active-low
En  in  1  block enable; low acts as a soft reset
baud_clk  in  1  single-cycle pulse, OVERSAMPLE pulses per bit
s_axis_tdata  in  DATA_W  transmit word
s_axis_tvalid  in  1  AXIS valid
s_axis_tready  out  1  AXIS ready
data_bits  in  3  0:8, 1:7, 2:6, 3:5, 4:9; 5–7 treated as 8
parity_mode  in  3  0:none, 1:even, 2:odd, 3:mark(1), 4:space(0); 5–7 treated as none
stop_bits  in  2  0:1, 1:1.5, 2 and 3:2
msb_first  in  1  1: data sent MSB first
send_break  in  1  single-cycle break request
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
busy  out  1  frame or break in progress
tc  out  1  one-cycle pulse: transmission complete, FIFO empty
break_done  out  1  one-cycle pulse at end of break sequence
txd  out  1  serial output, idle high

Behaviour:
- Reset or En low (synchronous, evaluated every Clk):
  - FIFO flushed; fifo_level=0; txd=1; busy=0; tc=0; break_done=0; s_axis_tready=0.
  - Any pending break is dropped.
  - A reset mid-frame aborts the frame; txd is 1 on the next cycle.
- FIFO:
  - s_axis_tready = !full, registered-state derived; it is 0 during reset and when En is low.
  - A write occurs when tvalid && tready.
  - Simultaneous push and pop leaves the level unchanged.
  - Pop happens only at frame start.
- States: IDLE, START, DATA, PARITY, STOP, BRK_LOW, BRK_MARK.
  - Every state except IDLE lasts OVERSAMPLE baud_clk pulses per bit.
  - Only baud_clk pulses advance the counters.
- IDLE, on a baud_clk pulse:
  - If a break is pending, go to BRK_LOW. Break has priority over FIFO data.
  - Else if the FIFO is non-empty: pop the word; latch data_bits, parity_mode, stop_bits and msb_first; go to START with txd=0 from the next Clk.
  - Config changes mid-frame take effect on the next frame only.
- Frame order: START (0) -> DATA (N bits) -> PARITY (if mode != none) -> STOP.
  - Parity is computed over the N transmitted bits only.
  - Even mode: parity bit = XOR of the bits. Odd mode: its inverse.
  - msb_first=1 sends bit N-1 first.
- STOP length:
  - 1.5 stop bits = OVERSAMPLE + OVERSAMPLE/2 pulses.
  - 2 stop bits = 2*OVERSAMPLE pulses.
- End of frame:
  - Back-to-back frames: on the pulse ending STOP, if the FIFO is non-empty and no break is pending, the next START begins with no idle bit.
  - Otherwise return to IDLE.
  - If the FIFO is empty and no break is pending, tc pulses for 1 Clk.
- send_break:
  - Sets a pending flag at any time; further requests while pending or in a break are ignored.
  - Taken at the next frame boundary.
  - BRK_LOW: txd=0 for BREAK_BITS bit-times.
  - BRK_MARK: txd=1 for 1 bit-time.
  - break_done pulses for 1 Clk on leaving BRK_MARK.
  - tc is not asserted for a break.
- busy: 1 in every state except IDLE. It goes to 0 in the same cycle tc pulses.
- txd is registered; there are no combinational paths from inputs to txd.

Decomposition:
- Package uart_pkg holds:
  - typedef enum for the FSM states;
  - typedefs parity_mode_t and stop_bits_t;
  - encoded-constant localparams;
  - function data_len(data_bits) returning 5..9.
- Sub-module axis_sync_fifo (parametrised WIDTH, DEPTH) provides the buffer, with push/pop/level/full/empty.

Test Plan:
- OVERSAMPLE=8, baud_clk held 1, 8N1 LSB-first, write 0xA5:
  - txd bits 0,1,0,1,0,0,1,0,1,1, each 8 cycles;
  - tc pulse after 80 pulses; busy=0 in the same cycle.
- 7 bits, MSB-first, 0x41:
  - even parity -> 0,1000001,0,1;
  - odd parity -> parity bit 1;
  - mark parity -> 1; space parity -> 0.
- 9 bits, 0x1FF, space parity, 2 stop bits: 13 bit-times = 104 pulses; parity bit 0; last 16 pulses high.
- 8N1.5: frame is 84 pulses. Back-to-back 0x00 and 0xFF written in advance: the second start bit follows the first stop with no idle gap; exactly one tc.
- FIFO_DEPTH=4 with baud_clk gated low, write 5 words: tready drops after 4 accepted; fifo_level=4; 5th word held until pops begin.
- send_break during a frame:
  - the frame completes;
  - then txd low for 88 pulses and high for 8;
  - break_done pulses; no tc;
  - Rst_n low mid-break -> txd=1 and fifo_level=0 on the next Clk.
